// File: rtl/instr_encoder_loader.sv
// Packs instruction fields into 16-bit program words and streams them into
// program memory from a latched base address, flagging bad opcodes and overflow.
module instr_encoder_loader #(
    parameter int PC_WIDTH          = 8,
    parameter int PROGRAM_DataWidth = 16,
    parameter int NumOpCodeBits     = 5,
    parameter int SEL_WIDTH         = 2,
    parameter int ParamBits         = 8
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     start,
    input  logic [PC_WIDTH-1:0]      base_adr,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [NumOpCodeBits-1:0] in_opcode,
    input  logic [SEL_WIDTH-1:0]     in_op1,
    input  logic [SEL_WIDTH-1:0]     in_op2,
    input  logic [ParamBits-1:0]     in_literal,
    input  logic                     in_last,
    output logic                     mem_wr_en,
    output logic [PC_WIDTH-1:0]      mem_adr,
    output logic [PROGRAM_DataWidth-1:0] mem_data,
    output logic                     busy,
    output logic                     done,
    output logic [1:0]               err_code,
    output logic [NumOpCodeBits-1:0] err_opcode,
    output logic [PC_WIDTH:0]        word_count
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_LOAD  = 2'd1,
        S_DONE  = 2'd2,
        S_ERROR = 2'd3
    } state_t;

    localparam logic [1:0]          ERR_NONE     = 2'b00;
    localparam logic [1:0]          ERR_RESERVED = 2'b01;
    localparam logic [1:0]          ERR_OVERFLOW = 2'b10;
    localparam logic [PC_WIDTH-1:0] ADR_TOP      = '1;

    state_t                         state_q;
    logic [PC_WIDTH-1:0]            adr_cnt_q;
    logic                           mem_wr_en_q;
    logic [PC_WIDTH-1:0]            mem_adr_q;
    logic [PROGRAM_DataWidth-1:0]   mem_data_q;
    logic [1:0]                     err_code_q;
    logic [NumOpCodeBits-1:0]       err_opcode_q;
    logic [PC_WIDTH:0]              word_count_q;

    logic [PROGRAM_DataWidth-1:0]   word_d;
    logic                           legal_d;

    // Field placement mirrors the decoder's unpacking; bit 10 is always 0.
    always_comb begin
        word_d  = '0;
        legal_d = 1'b1;
        word_d[15:11] = in_opcode;
        case (in_opcode)
            5'h00: word_d = '0;
            5'h01, 5'h02, 5'h03, 5'h04, 5'h05, 5'h06: begin
                word_d[9:8] = in_op1;
                word_d[4:3] = in_op2;
            end
            5'h07, 5'h08, 5'h09: begin
                word_d[9:8] = in_op1;
                word_d[7:0] = in_literal;
            end
            5'h10, 5'h11, 5'h12: word_d[7:0] = in_literal;
            default: legal_d = 1'b0;
        endcase
    end

    assign in_ready   = (state_q == S_LOAD);
    assign busy       = (state_q == S_LOAD);
    assign done       = (state_q == S_DONE);
    assign mem_wr_en  = mem_wr_en_q;
    assign mem_adr    = mem_adr_q;
    assign mem_data   = mem_data_q;
    assign err_code   = err_code_q;
    assign err_opcode = err_opcode_q;
    assign word_count = word_count_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= S_IDLE;
            adr_cnt_q    <= '0;
            mem_wr_en_q  <= 1'b0;
            mem_adr_q    <= '0;
            mem_data_q   <= '0;
            err_code_q   <= ERR_NONE;
            err_opcode_q <= '0;
            word_count_q <= '0;
        end else begin
            mem_wr_en_q <= 1'b0;
            case (state_q)
                S_LOAD: begin
                    if (in_valid) begin
                        if (!legal_d) begin
                            state_q      <= S_ERROR;
                            err_code_q   <= ERR_RESERVED;
                            err_opcode_q <= in_opcode;
                        end else begin
                            mem_wr_en_q  <= 1'b1;
                            mem_adr_q    <= adr_cnt_q;
                            mem_data_q   <= word_d;
                            word_count_q <= word_count_q + (PC_WIDTH+1)'(1);
                            if (adr_cnt_q != ADR_TOP)
                                adr_cnt_q <= adr_cnt_q + PC_WIDTH'(1);
                            if (in_last) begin
                                state_q <= S_DONE;
                            end else if (adr_cnt_q == ADR_TOP) begin
                                state_q    <= S_ERROR;
                                err_code_q <= ERR_OVERFLOW;
                            end
                        end
                    end
                end
                default: begin
                    if (start) begin
                        state_q      <= S_LOAD;
                        adr_cnt_q    <= base_adr;
                        word_count_q <= '0;
                        err_code_q   <= ERR_NONE;
                        err_opcode_q <= '0;
                    end
                end
            endcase
        end
    end

endmodule

// File: doc/instr_encoder_loader.md
Name: instr_encoder_loader

Overview:
Writer-side counterpart of the instruction decoder. It accepts instruction fields (opcode, operand registers, literal) over a valid/ready stream and packs them into 16-bit instruction words. The packing uses the exact bit layout the decoder unpacks. Packed words are written sequentially into program memory starting at a base address. The block sits between the test/boot host (or a serial loader) and the program memory write port, and flags illegal opcodes and address-space overflow.

Parameters:
PC_WIDTH, 8, program memory address width
PROGRAM_DataWidth, 16, instruction word width
NumOpCodeBits, 5, opcode field width (word bits 15:11)
SEL_WIDTH, 2, register-select field width (op1 at bits 9:8, op2 at bits 4:3)
ParamBits, 8, literal/param field width (bits 7:0)

Ports:
clk  in  1  clock, all state on rising edge
reset  in  1  asynchronous, active-high reset
start  in  1  begin a load session; sampled in IDLE, DONE and ERROR
base_adr  in  PC_WIDTH  first program memory address, latched on start
in_valid  in  1  field set valid
in_ready  out  1  block can accept a field set
in_opcode  in  5  opcode
in_op1  in  2  destination/first register
in_op2  in  2  second register
in_literal  in  8  literal, jump target/offset, or shift count
in_last  in  1  marks the final word of the session
mem_wr_en  out  1  program memory write strobe, one cycle per word
mem_adr  out  PC_WIDTH  write address
mem_data  out  16  packed instruction word
busy  out  1  high in LOAD
done  out  1  high in DONE
err_code  out  2  00 none, 01 reserved opcode, 10 address overflow
err_opcode  out  5  offending opcode, valid when err_code=01
word_count  out  PC_WIDTH+1  words written since the last start

Behaviour:
- Reset (asynchronous, any state): state=IDLE. in_ready, mem_wr_en, busy and done are 0. mem_adr, mem_data, err_code, err_opcode and word_count are 0. A write pending from a prior accept is dropped.
- States: IDLE, LOAD, DONE, ERROR.
- Entering LOAD: start=1 in IDLE, DONE or ERROR moves to LOAD, latches base_adr into adr_cnt, and clears word_count, err_code and err_opcode. start in LOAD is ignored.
- in_ready = (state==LOAD), combinational from state. Accept = in_valid & in_ready.
- Latency: a legal accept in cycle N produces mem_wr_en=1 in cycle N+1, with mem_adr=adr_cnt and mem_data=packed word. adr_cnt and word_count increment at the same edge.
- Throughput: back-to-back accepts are allowed, one word per cycle. mem_adr and mem_data hold their last value when mem_wr_en=0.
- Packing: word[15:11]=opcode, word[10]=0. All bits not listed below are 0.
  - ADD 01, SUB 02, AND 03, OR 04, XOR 06, NOT 05: [9:8]=op1, [4:3]=op2.
  - SHL 07, SHR 08, VAL 09: [9:8]=op1, [7:0]=literal.
  - GOTO 10, IFZ 11, IFNZ 12: [7:0]=literal.
  - NOP 00: all fields zero, so the word is 0x0000.
- Reserved opcodes: 0A-0F and 13-1F. This includes IFEQ, IFST and IFGT, which stay rejected until the decoder implements them. On accept, nothing is written. Next state is ERROR, err_code=01, err_opcode=in_opcode.
- Termination: accepting a legal word with in_last=1 writes it, and the next state is DONE.
- Overflow: accepting a legal word at adr_cnt = 2^PC_WIDTH-1 with in_last=0 writes it, and the next state is ERROR with err_code=10. adr_cnt never wraps into a write.
- If in_last=1 at the top address, the word is written and the next state is DONE (no overflow).
- DONE/ERROR: in_ready=0, and state is held until start or reset. word_count stays readable.
- Simultaneous start and in_valid in DONE: the start is taken. The field set is not accepted that cycle because in_ready=0.

Test Plan:
- Reset, start with base_adr=0x20, then ADD op1=2 op2=1, last=0 -> one cycle later mem_wr_en=1, mem_adr=0x20, mem_data=0x0A08; word_count=1.
- Back-to-back VAL op1=3 lit=0x5A, then SHL op1=1 lit=2, then GOTO lit=0x10 last=1 -> writes on three consecutive cycles: 0x4B5A@0x20, 0x3902@0x21, 0x8010@0x22. Afterwards done=1, in_ready=0, word_count=3.
- Start, NOP, then opcode 0x0A -> 0x0000 written at base. Reserved word not written; err_code=01, err_opcode=0x0A, in_ready=0. A second start clears the error and returns to LOAD.
- base_adr=0xFE, three words with last=0 -> writes at 0xFE and 0xFF, then err_code=10. The third word is never accepted and word_count=2.
- Assert reset while streaming, in the cycle after an accept -> no mem_wr_en that cycle and all outputs are 0. After a start, base_adr is reloaded and writing resumes correctly.
- IFZ lit=0x03 with in_valid held and start pulsed while in LOAD -> start ignored, 0x8803 written, adr_cnt continues.
